alu_ex_stage: RTL
=================

Name: alu_ex_stage

Overview:
- Registered execute stage sitting directly downstream of the ALU-control decoder in the myCPU datapath.
- Consumes the 3-bit ALU control code together with two operands and a writeback tag. Computes the result and delivers it to the EX/MEM side through a valid/ready handshake.
- Holds a two-entry buffer (output register plus skid register), so the stage never drops data and never creates a combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 32, operand/result width in bits
- TAG_W, 8, width of opaque sideband (dest reg, regwrite, memtoreg…) carried alongside the result

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream has an operation
- in_ready  out  1  stage can accept; equals !skid_valid (registered)
- aluctrl  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result held on outputs is valid
- out_ready  in  1  downstream accepts this cycle
- result  out  WIDTH  ALU result
- zero  out  1  result == 0 (BEQ decision)
- ovf  out  1  signed overflow on ADD/SUB; 0 for other ops
- illegal  out  1  aluctrl was an undefined code
- out_tag  out  TAG_W  sideband of the result on the outputs

Behaviour:
- Reset (resetn low, async): out_valid=0, skid_valid=0, result=0, zero=0, ovf=0, illegal=0, out_tag=0. in_ready reads 1 as soon as reset deasserts.
- Accept condition: in_valid && in_ready. Computation is combinational on the inputs and captured at accept, so latency is one cycle from accept to out_valid.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf = sign(a)==sign(b') && sign(res)!=sign(a), where b' is op_b for ADD and ~op_b+1 semantics for SUB (signed compare).
  - SLT is a signed comparison, giving result {0…,1} or 0.
  - Illegal codes give result=0, illegal=1, ovf=0.
  - zero is computed from the final result for every op.
- Output register loads when !out_valid || out_ready:
  - source is the skid entry if skid_valid, else the accepted input.
  - If it loads from skid, any simultaneous accept goes into skid. Skid stays valid and the order is preserved.
- Stall: accept while out_valid && !out_ready writes the skid register; in_ready drops the next cycle.
- Full: out_valid && skid_valid → in_ready=0. A later out_ready moves skid to output, and in_ready=1 the next cycle.
- Simultaneous accept and drain with an empty skid: new entry goes straight to the output register; no bubble.
- Throughput: one op per cycle while out_ready stays high.
- Outputs are stable while out_valid && !out_ready: no change to result, zero, ovf, illegal or out_tag.
- flush:
  - clears out_valid and skid_valid at the next edge.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - Data registers may retain stale values.
  - flush has priority over accept and drain.
- Reset mid-operation discards all entries immediately (async).
- Ordering: strict FIFO; entries are never reordered or duplicated.

Decomposition:
- Shared package/header (alongside defines2.vh): ALU control code constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
- One combinational sub-module alu_core(aluctrl, a, b → result, zero, ovf, illegal), instantiated once before the buffer.
- The stage module contains only the handshake and the two-entry buffer.

Test Plan:
- Basic ops, out_ready=1, back-to-back:
  - ADD 5+7 → result=12, zero=0
  - SUB 7-7 → 0, zero=1
  - AND 0xF0F0&0x0FF0 → 0x00F0
  - OR 0x1234|0x0001 → 0x1235
  - SLT -1<1 → 1
  - Each appears exactly one cycle after accept, in order.
- Overflow and illegal:
  - ADD 0x7FFFFFFF+1 → result=0x80000000, ovf=1
  - SUB 0x80000000-1 → ovf=1
  - aluctrl=3'b011 → result=0, illegal=1
- Backpressure: hold out_ready=0 and push tags A,B,C.
  - A on the outputs, B in skid, in_ready=0 so C is held.
  - Release out_ready → outputs A,B,C on consecutive accepts, each exactly once, outputs stable while stalled.
- Flush with full buffer: assert flush while in_valid=1 → next cycle out_valid=0, in_ready=1, and the input from the flush cycle is never output.
- Async reset: drop resetn mid-stream between clock edges → out_valid=0 and result=0 immediately. After release the first op completes normally with latency 1.

Source files
------------

// File: rtl/alu_ex_stage_pkg.sv
// alu_ex_stage_pkg: ALU control code constants shared by the execute stage and its ALU core.
package alu_ex_stage_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_legal(input logic [2:0] c);
    return c inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
  endfunction
endpackage

// File: rtl/alu_ex_stage_alu_core.sv
// alu_core: combinational ALU computing result, zero, signed overflow and illegal-code flags.
module alu_core
  import alu_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       aluctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);
  logic [WIDTH-1:0] sum, diff;
  logic             slt;

  always_comb begin
    sum = a + b;
    diff = a - b;
    slt = $signed(a) < $signed(b);
    illegal = !is_legal(aluctrl);
    result = aluctrl == ALU_AND ? a & b :
             aluctrl == ALU_OR  ? a | b :
             aluctrl == ALU_ADD ? sum :
             aluctrl == ALU_SUB ? diff :
             aluctrl == ALU_SLT ? {{(WIDTH-1){1'b0}}, slt} : '0;
    // true two's-complement overflow of a+b and a-b
    ovf = aluctrl == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
          aluctrl == ALU_SUB ? (a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    zero = result == '0;
  end
endmodule

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: registered ALU execute stage with a two-entry (output + skid) valid/ready buffer.
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);
  localparam int EW = WIDTH + 3 + TAG_W;

  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_ovf, alu_ill;
  logic [EW-1:0]    in_e, out_d, out_q, skid_d, skid_q;
  logic             out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
  logic             accept, load_out;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .aluctrl(aluctrl),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res),
    .zero   (alu_zero),
    .ovf    (alu_ovf),
    .illegal(alu_ill)
  );

  assign in_e = {alu_res, alu_zero, alu_ovf, alu_ill, in_tag};

  // skid entry always drains ahead of a new accept to keep FIFO order
  always_comb begin
    accept = in_valid && !skid_valid_q && !flush;
    load_out = !out_valid_q || out_ready;
    out_valid_d = flush ? 1'b0 : load_out ? (skid_valid_q || accept) : 1'b1;
    out_d = (load_out && (skid_valid_q || accept)) ? (skid_valid_q ? skid_q : in_e) : out_q;
    skid_valid_d = flush ? 1'b0 : load_out ? (skid_valid_q && accept) : (skid_valid_q || accept);
    skid_d = (accept && (!load_out || skid_valid_q)) ? in_e : skid_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
  end

  assign in_ready = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign {result, zero, ovf, illegal, out_tag} = out_q;
endmodule
